// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Latches the execute payload, captures the synchronous SRAM read word,
// holds it across write-back stalls and applies load byte/half extraction.
module mem_stage #(
    parameter int EXE_TO_MEM_LEN = 112,
    parameter int MEM_TO_WB_LEN  = 70,
    parameter int MEM_RF_LEN     = 37
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
    input  logic                      EXE_to_MEM_valid,
    output logic                      MEM_allowin,
    input  logic [31:0]               data_sram_rdata,
    input  logic                      WB_allowin,
    output logic                      MEM_to_WB_valid,
    output logic [MEM_TO_WB_LEN-1:0]  MEM_to_WB_BUS,
    output logic [MEM_RF_LEN-1:0]     MEM_RF_BUS
);

    logic                      mem_valid;
    logic                      first_cycle;
    logic                      rdata_held;
    logic [31:0]               rdata_buf;
    logic [EXE_TO_MEM_LEN-1:0] payload;
    logic                      accept;

    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [3:0]  load_op;
    logic        rfrom_mem;
    logic        unused_payload_bits;

    logic [1:0]  addr_lo;
    logic [31:0] raw_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [31:0] final_result;

    // The stage never needs extra cycles, so it frees up whenever write-back takes the current entry
    assign MEM_allowin     = !mem_valid || WB_allowin;
    assign MEM_to_WB_valid = mem_valid;
    assign accept          = EXE_to_MEM_valid && MEM_allowin;

    assign pc         = payload[EXE_TO_MEM_LEN-1 -: 32];
    assign gr_we      = payload[79];
    assign dest       = payload[78:74];
    assign exe_result = payload[73:42];
    assign load_op    = payload[4:1];
    assign rfrom_mem  = payload[0];

    // Address/store fields are consumed upstream by the SRAM request, not here
    assign unused_payload_bits = ^payload[41:5];

    // Valid bit follows the upstream valid whenever the stage can take a new entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (MEM_allowin) begin
            mem_valid <= EXE_to_MEM_valid;
        end
    end

    // Payload register only changes on a real handshake, so a stalled entry is never overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload <= '0;
        end else if (accept) begin
            payload <= EXE_to_MEM_BUS;
        end
    end

    // Marks the single cycle in which the SRAM read data belongs to the current entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_cycle <= 1'b0;
        end else begin
            first_cycle <= accept;
        end
    end

    // Capture the SRAM word at the end of its only valid cycle if write-back is stalling us
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_buf  <= '0;
            rdata_held <= 1'b0;
        end else if (MEM_allowin) begin
            rdata_held <= 1'b0;
        end else if (mem_valid && first_cycle && rfrom_mem && !WB_allowin) begin
            rdata_buf  <= data_sram_rdata;
            rdata_held <= 1'b1;
        end
    end

    assign raw_word = rdata_held ? rdata_buf : data_sram_rdata;
    assign addr_lo  = exe_result[1:0];
    assign sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    // Pick the addressed byte out of the raw word
    always_comb begin
        sel_byte = raw_word[7:0];
        case (addr_lo)
            2'd0: sel_byte = raw_word[7:0];
            2'd1: sel_byte = raw_word[15:8];
            2'd2: sel_byte = raw_word[23:16];
            2'd3: sel_byte = raw_word[31:24];
            default: sel_byte = raw_word[7:0];
        endcase
    end

    // One-hot load_op selects width and extension; no bits set means a full word load
    always_comb begin
        load_value = raw_word;
        if (load_op[0]) begin
            load_value = {{24{sel_byte[7]}}, sel_byte};
        end else if (load_op[1]) begin
            load_value = {{16{sel_half[15]}}, sel_half};
        end else if (load_op[2]) begin
            load_value = {24'd0, sel_byte};
        end else if (load_op[3]) begin
            load_value = {16'd0, sel_half};
        end
    end

    assign final_result  = rfrom_mem ? load_value : exe_result;
    assign MEM_to_WB_BUS = {pc, gr_we, dest, final_result};
    assign MEM_RF_BUS    = {((gr_we && mem_valid) ? dest : 5'd0), final_result};

endmodule
